// File: rtl/ex_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ex_pkg
// Description : Shared types and constants for the RV32 execute stage.
//               - ctrl_t: the pipeline control bundle. An all-zero value is a
//                 bubble.
//               - ALU_*: the 4-bit ALU operation codes.
//               - FWD_*: the forwarding mux selects.
//               - ALUOP_*: the main-decoder alu_op classes.
// Revision    : 1.0 - initial release
// ============================================================================
package ex_pkg;

    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic branch;
        logic alu_src;
    } ctrl_t;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_SLL  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SRA  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    localparam logic [1:0] FWD_REG  = 2'b00;
    localparam logic [1:0] FWD_WB   = 2'b01;
    localparam logic [1:0] FWD_MEM  = 2'b10;

    localparam logic [1:0] ALUOP_LDST   = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE  = 2'b10;

endpackage
`default_nettype wire

// File: rtl/ex_stage_alu.sv
`default_nettype none
// ============================================================================
// Module      : alu
// Description : Combinational RV32 ALU.
//               Inputs : alu_ctrl (4-bit operation code), a, b (XLEN operands).
//               Outputs: result (XLEN), zero (set when result == 0).
//               Shifts use the low $clog2(XLEN) bits of b. Codes that are not
//               defined produce a zero result.
// Revision    : 1.0 - initial release
// ============================================================================
module alu
    import ex_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [3:0]      alu_ctrl,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] result,
    output logic            zero
);

    localparam int SHW = $clog2(XLEN);

    logic [SHW-1:0]  w_shamt;
    logic [XLEN-1:0] w_result;

    assign w_shamt = b[SHW-1:0];

    always_comb begin
        w_result = '0;
        case (alu_ctrl)
            ALU_AND:  w_result = a & b;
            ALU_OR:   w_result = a | b;
            ALU_ADD:  w_result = a + b;
            ALU_XOR:  w_result = a ^ b;
            ALU_SLL:  w_result = a << w_shamt;
            ALU_SRL:  w_result = a >> w_shamt;
            ALU_SRA:  w_result = $unsigned($signed(a) >>> w_shamt);
            ALU_SUB:  w_result = a - b;
            ALU_SLT:  w_result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU: w_result = {{(XLEN-1){1'b0}}, (a < b)};
            default:  w_result = '0;
        endcase
    end

    assign result = w_result;
    assign zero   = (w_result == '0);

endmodule
`default_nettype wire

// File: rtl/ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : ex_stage
// Description : Execute stage of a 5-stage RV32 pipeline. It contains the
//               ID/EX register, the operand forwarding muxes, the ALU, BEQ
//               resolution and the EX/MEM register.
//
//   Inputs from decode : id_rs1_data, id_rs2_data, id_imm, id_rs, id_rd,
//                        id_alu_op, id_funct3, id_funct7_bit, id_ctrl
//   Pipeline control   : stall (holds both registers),
//                        flush (loads a bubble into ID/EX)
//   To ALUControl      : alu_op, funct3, funct7_bit
//                        (alu_ctrl returns in the same cycle)
//   Forwarding         : ex_rs goes out; fwd_sel, mem_fwd_data and
//                        wb_fwd_data come in
//   To memory stage    : exm_result, exm_store_data, exm_rd, exm_ctrl,
//                        exm_branch_taken
//
//   Macro EX_FORWARD_EN: when defined, the forwarding muxes are built. When
//   it is undefined, the operands come only from the ID/EX register and the
//   forwarding ports are ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module ex_stage
    import ex_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            flush,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic [9:0]      id_rs,
    input  logic [4:0]      id_rd,
    input  logic [1:0]      id_alu_op,
    input  logic [2:0]      id_funct3,
    input  logic            id_funct7_bit,
    input  logic [4:0]      id_ctrl,
    output logic [1:0]      alu_op,
    output logic [2:0]      funct3,
    output logic            funct7_bit,
    input  logic [3:0]      alu_ctrl,
    output logic [9:0]      ex_rs,
    input  logic [3:0]      fwd_sel,
    input  logic [XLEN-1:0] mem_fwd_data,
    input  logic [XLEN-1:0] wb_fwd_data,
    output logic [XLEN-1:0] exm_result,
    output logic [XLEN-1:0] exm_store_data,
    output logic [4:0]      exm_rd,
    output logic [4:0]      exm_ctrl,
    output logic            exm_branch_taken
);

    // ID/EX register
    logic [XLEN-1:0] r_rs1_data;
    logic [XLEN-1:0] r_rs2_data;
    logic [XLEN-1:0] r_imm;
    logic [9:0]      r_rs;
    logic [4:0]      r_rd;
    logic [1:0]      r_alu_op;
    logic [2:0]      r_funct3;
    logic            r_funct7_bit;
    ctrl_t           r_ctrl;

    // EX/MEM register
    logic [XLEN-1:0] r_exm_result;
    logic [XLEN-1:0] r_exm_store_data;
    logic [4:0]      r_exm_rd;
    ctrl_t           r_exm_ctrl;
    logic            r_exm_branch_taken;

    logic [XLEN-1:0] w_fwd_a;
    logic [XLEN-1:0] w_fwd_b;
    logic [XLEN-1:0] w_alu_b;
    logic [XLEN-1:0] w_result;
    logic            w_zero;
    ctrl_t           w_exm_ctrl_d;

    // Flush takes priority over stall, so a bubble can be inserted even while
    // the front of the pipe is frozen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rs1_data   <= '0;
            r_rs2_data   <= '0;
            r_imm        <= '0;
            r_rs         <= '0;
            r_rd         <= '0;
            r_alu_op     <= '0;
            r_funct3     <= '0;
            r_funct7_bit <= 1'b0;
            r_ctrl       <= '0;
        end else if (flush) begin
            r_rs1_data   <= '0;
            r_rs2_data   <= '0;
            r_imm        <= '0;
            r_rs         <= '0;
            r_rd         <= '0;
            r_alu_op     <= '0;
            r_funct3     <= '0;
            r_funct7_bit <= 1'b0;
            r_ctrl       <= '0;
        end else if (!stall) begin
            r_rs1_data   <= id_rs1_data;
            r_rs2_data   <= id_rs2_data;
            r_imm        <= id_imm;
            r_rs         <= id_rs;
            r_rd         <= id_rd;
            r_alu_op     <= id_alu_op;
            r_funct3     <= id_funct3;
            r_funct7_bit <= id_funct7_bit;
            r_ctrl       <= ctrl_t'(id_ctrl);
        end
    end

    // alu_ctrl is decoded outside from these registered fields only, so
    // feeding it back into the ALU cannot form a combinational loop.
    assign alu_op     = r_alu_op;
    assign funct3     = r_funct3;
    assign funct7_bit = r_funct7_bit;
    assign ex_rs      = r_rs;

    always_comb begin
        w_fwd_a = r_rs1_data;
        w_fwd_b = r_rs2_data;
`ifdef EX_FORWARD_EN
        // A select value of 11 is not a valid source, so it falls back to
        // the register value.
        case (fwd_sel[1:0])
            FWD_WB:  w_fwd_a = wb_fwd_data;
            FWD_MEM: w_fwd_a = mem_fwd_data;
            default: w_fwd_a = r_rs1_data;
        endcase
        case (fwd_sel[3:2])
            FWD_WB:  w_fwd_b = wb_fwd_data;
            FWD_MEM: w_fwd_b = mem_fwd_data;
            default: w_fwd_b = r_rs2_data;
        endcase
`endif
    end

`ifndef EX_FORWARD_EN
    // The forwarding ports stay in place but are unused in this build.
    logic w_unused_fwd;
    assign w_unused_fwd = ^{fwd_sel, mem_fwd_data, wb_fwd_data};
`endif

    assign w_alu_b = r_ctrl.alu_src ? r_imm : w_fwd_b;

    alu #(
        .XLEN(XLEN)
    ) u_alu (
        .alu_ctrl(alu_ctrl),
        .a       (w_fwd_a),
        .b       (w_alu_b),
        .result  (w_result),
        .zero    (w_zero)
    );

    // x0 is hard-wired to zero, so a write to it is cancelled here. This
    // keeps later stages from ever seeing a write to x0.
    always_comb begin
        w_exm_ctrl_d = r_ctrl;
        if (r_rd == 5'd0) begin
            w_exm_ctrl_d.reg_write = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_exm_result       <= '0;
            r_exm_store_data   <= '0;
            r_exm_rd           <= '0;
            r_exm_ctrl         <= '0;
            r_exm_branch_taken <= 1'b0;
        end else if (!stall) begin
            r_exm_result       <= w_result;
            r_exm_store_data   <= w_fwd_b;
            r_exm_rd           <= r_rd;
            r_exm_ctrl         <= w_exm_ctrl_d;
            r_exm_branch_taken <= r_ctrl.branch & w_zero;
        end
    end

    assign exm_result       = r_exm_result;
    assign exm_store_data   = r_exm_store_data;
    assign exm_rd           = r_exm_rd;
    assign exm_ctrl         = r_exm_ctrl;
    assign exm_branch_taken = r_exm_branch_taken;

endmodule
`default_nettype wire

// File: tb/tb_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_ex_stage
// Description : Self-checking bench for ex_stage. It includes an ALUControl
//               model and an instruction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_stage;

`ifdef EX_FORWARD_EN
    localparam bit FWD_ON = 1'b1;
`else
    localparam bit FWD_ON = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] r1;
        logic [31:0] r2;
        logic [31:0] imm;
        logic [9:0]  rs;
        logic [4:0]  rd;
        logic [1:0]  aop;
        logic [2:0]  f3;
        logic        f7;
        logic [4:0]  ctrl;   // {reg_write, mem_read, mem_write, branch, alu_src}
    } instr_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, flush;
    logic [31:0] id_rs1_data, id_rs2_data, id_imm;
    logic [9:0]  id_rs;
    logic [4:0]  id_rd;
    logic [1:0]  id_alu_op;
    logic [2:0]  id_funct3;
    logic        id_funct7_bit;
    logic [4:0]  id_ctrl;
    logic [1:0]  alu_op;
    logic [2:0]  funct3;
    logic        funct7_bit;
    logic [3:0]  alu_ctrl;
    logic [9:0]  ex_rs;
    logic [3:0]  fwd_sel;
    logic [31:0] mem_fwd_data, wb_fwd_data;
    logic [31:0] exm_result, exm_store_data;
    logic [4:0]  exm_rd, exm_ctrl;
    logic        exm_branch_taken;

    logic        ovr_en;
    logic [3:0]  ovr_code;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ex_stage #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs(id_rs), .id_rd(id_rd), .id_alu_op(id_alu_op), .id_funct3(id_funct3),
        .id_funct7_bit(id_funct7_bit), .id_ctrl(id_ctrl),
        .alu_op(alu_op), .funct3(funct3), .funct7_bit(funct7_bit), .alu_ctrl(alu_ctrl),
        .ex_rs(ex_rs), .fwd_sel(fwd_sel), .mem_fwd_data(mem_fwd_data), .wb_fwd_data(wb_fwd_data),
        .exm_result(exm_result), .exm_store_data(exm_store_data), .exm_rd(exm_rd),
        .exm_ctrl(exm_ctrl), .exm_branch_taken(exm_branch_taken)
    );

    // External ALUControl: classic RV32 decode from alu_op/funct3/funct7 bit.
    function automatic logic [3:0] aluctl_model(input logic [1:0] aop, input logic [2:0] f3, input logic f7);
        case (aop)
            2'b00: return 4'b0010;
            2'b01: return 4'b0110;
            2'b10: begin
                case (f3)
                    3'b000: return f7 ? 4'b0110 : 4'b0010;
                    3'b001: return 4'b0100;
                    3'b010: return 4'b0111;
                    3'b011: return 4'b1001;
                    3'b100: return 4'b0011;
                    3'b101: return f7 ? 4'b1000 : 4'b0101;
                    3'b110: return 4'b0001;
                    default: return 4'b0000;
                endcase
            end
            default: return 4'b1111;
        endcase
    endfunction

    always_comb begin
        alu_ctrl = aluctl_model(alu_op, funct3, funct7_bit);
        if (ovr_en) alu_ctrl = ovr_code;
    end

    // Reference model: the result of an instruction, from its instruction fields.
    function automatic logic [31:0] ref_result(input logic [1:0] aop, input logic [2:0] f3, input logic f7,
                                               input logic [31:0] a, input logic [31:0] b);
        case (aop)
            2'b00: return a + b;
            2'b01: return a - b;
            2'b10: begin
                case (f3)
                    3'b000: return f7 ? a - b : a + b;
                    3'b001: return a << b[4:0];
                    3'b010: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    3'b011: return (a < b) ? 32'd1 : 32'd0;
                    3'b100: return a ^ b;
                    3'b101: return f7 ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
                    3'b110: return a | b;
                    default: return a & b;
                endcase
            end
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] pick(input logic [1:0] s, input logic [31:0] reg_v,
                                         input logic [31:0] mem_v, input logic [31:0] wb_v);
        if (FWD_ON && s == 2'b01) return wb_v;
        if (FWD_ON && s == 2'b10) return mem_v;
        return reg_v;
    endfunction

    function automatic instr_t mk(input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] imm,
                                  input logic [4:0] rd, input logic [1:0] aop, input logic [2:0] f3,
                                  input logic f7, input logic [4:0] ctrl);
        instr_t t;
        t.r1 = r1; t.r2 = r2; t.imm = imm; t.rs = {5'd2, 5'd1}; t.rd = rd;
        t.aop = aop; t.f3 = f3; t.f7 = f7; t.ctrl = ctrl;
        return t;
    endfunction

    task automatic drive_id(input instr_t t);
        id_rs1_data = t.r1; id_rs2_data = t.r2; id_imm = t.imm; id_rs = t.rs; id_rd = t.rd;
        id_alu_op = t.aop; id_funct3 = t.f3; id_funct7_bit = t.f7; id_ctrl = t.ctrl;
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 0; flush = 0; fwd_sel = 0; mem_fwd_data = 0; wb_fwd_data = 0;
        ovr_en = 0; ovr_code = 0;
        drive_id(mk(32'h1234, 32'h5678, 32'h9, 5'd7, 2'b10, 3'b111, 1'b1, 5'b11111));
        @(negedge clk); @(negedge clk);
        n_checks++; if (exm_result !== 32'd0) begin n_fail++; $display("FAIL reset_result: got %h want 0", exm_result); end
        n_checks++; if (exm_store_data !== 32'd0) begin n_fail++; $display("FAIL reset_store: got %h want 0", exm_store_data); end
        n_checks++; if ({exm_rd, exm_ctrl, exm_branch_taken} !== 11'd0) begin n_fail++; $display("FAIL reset_exm_ctl: got rd=%h ctrl=%b bt=%b want 0", exm_rd, exm_ctrl, exm_branch_taken); end
        n_checks++; if ({alu_op, funct3, funct7_bit, ex_rs} !== 16'd0) begin n_fail++; $display("FAIL reset_idex: got aop=%b f3=%b f7=%b rs=%h want 0", alu_op, funct3, funct7_bit, ex_rs); end
        rst = 1'b0;
    endtask

    task automatic test_add_sub();
        @(negedge clk); drive_id(mk(32'd5, 32'd7, 32'd0, 5'd3, 2'b10, 3'b000, 1'b0, 5'b10000));
        @(negedge clk); drive_id(mk(32'd5, 32'd7, 32'd0, 5'd4, 2'b10, 3'b000, 1'b1, 5'b10000));
        @(negedge clk);
        n_checks++; if (exm_result !== 32'd12) begin n_fail++; $display("FAIL add: got %h want 0000000c", exm_result); end
        n_checks++; if (exm_rd !== 5'd3 || exm_ctrl !== 5'b10000) begin n_fail++; $display("FAIL add_rd_ctrl: got rd=%0d ctrl=%b want 3 10000", exm_rd, exm_ctrl); end
        drive_id('0);
        @(negedge clk);
        n_checks++; if (exm_result !== 32'hFFFFFFFE) begin n_fail++; $display("FAIL sub: got %h want fffffffe", exm_result); end
    endtask

    task automatic test_beq();
        @(negedge clk); drive_id(mk(32'h10, 32'h10, 32'd0, 5'd0, 2'b01, 3'b000, 1'b0, 5'b00010));
        @(negedge clk); drive_id(mk(32'h10, 32'h11, 32'd0, 5'd0, 2'b01, 3'b000, 1'b0, 5'b00010));
        @(negedge clk);
        n_checks++; if (exm_branch_taken !== 1'b1) begin n_fail++; $display("FAIL beq_taken: got %b want 1", exm_branch_taken); end
        drive_id('0);
        @(negedge clk);
        n_checks++; if (exm_branch_taken !== 1'b0) begin n_fail++; $display("FAIL beq_not_taken: got %b want 0", exm_branch_taken); end
        n_checks++; if (exm_result !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL beq_diff: got %h want ffffffff", exm_result); end
    endtask

    task automatic test_forward();
        logic [31:0] want;
        @(negedge clk); drive_id(mk(32'd1, 32'd55, 32'd3, 5'd9, 2'b00, 3'b010, 1'b0, 5'b10001));
        @(negedge clk); drive_id('0);
        fwd_sel = 4'b0010; mem_fwd_data = 32'd100; wb_fwd_data = 32'd200;
        @(negedge clk);
        want = FWD_ON ? 32'd103 : 32'd4;
        n_checks++; if (exm_result !== want) begin n_fail++; $display("FAIL fwd_a_mem: got %0d want %0d", exm_result, want); end
        // The B operand of a store goes to store_data; select WB for B and 11 (register) for A.
        drive_id(mk(32'd10, 32'd20, 32'd8, 5'd0, 2'b00, 3'b010, 1'b0, 5'b00101));
        @(negedge clk); drive_id('0);
        fwd_sel = 4'b0111;
        @(negedge clk);
        want = FWD_ON ? 32'd200 : 32'd20;
        n_checks++; if (exm_store_data !== want) begin n_fail++; $display("FAIL fwd_b_wb: got %0d want %0d", exm_store_data, want); end
        n_checks++; if (exm_result !== 32'd18) begin n_fail++; $display("FAIL fwd_sel11_reg: got %0d want 18", exm_result); end
        fwd_sel = 4'b0000;
    endtask

    task automatic test_stall_flush();
        @(negedge clk); drive_id(mk(32'd40, 32'd2, 32'd0, 5'd6, 2'b10, 3'b000, 1'b0, 5'b10000));
        @(negedge clk); drive_id(mk(32'd9, 32'd9, 32'd0, 5'd8, 2'b10, 3'b100, 1'b0, 5'b11000));
        @(negedge clk);   // exm = 42, ID/EX = XOR instr
        stall = 1'b1; drive_id(mk(32'd77, 32'd1, 32'd0, 5'd5, 2'b10, 3'b110, 1'b0, 5'b10000));
        @(negedge clk); @(negedge clk);
        n_checks++; if (exm_result !== 32'd42 || exm_rd !== 5'd6) begin n_fail++; $display("FAIL stall_hold_exm: got %0d rd=%0d want 42 rd=6", exm_result, exm_rd); end
        n_checks++; if (funct3 !== 3'b100) begin n_fail++; $display("FAIL stall_hold_idex: got f3=%b want 100", funct3); end
        flush = 1'b1;
        @(negedge clk);
        n_checks++; if (alu_op !== 2'b00 || funct3 !== 3'b000 || ex_rs !== 10'd0) begin n_fail++; $display("FAIL flush_under_stall: got aop=%b f3=%b rs=%h want 0", alu_op, funct3, ex_rs); end
        n_checks++; if (exm_result !== 32'd42) begin n_fail++; $display("FAIL flush_keeps_exm: got %0d want 42", exm_result); end
        flush = 1'b0; stall = 1'b0; drive_id('0);
        @(negedge clk);
        n_checks++; if (exm_ctrl !== 5'd0 || exm_rd !== 5'd0) begin n_fail++; $display("FAIL flush_bubble: got ctrl=%b rd=%0d want 0", exm_ctrl, exm_rd); end
    endtask

    task automatic test_rd_zero_sra();
        @(negedge clk); drive_id(mk(32'd1, 32'd1, 32'd0, 5'd0, 2'b10, 3'b000, 1'b0, 5'b11000));
        @(negedge clk); drive_id(mk(32'h80000000, 32'd4, 32'd0, 5'd12, 2'b10, 3'b101, 1'b1, 5'b10000));
        @(negedge clk);
        n_checks++; if (exm_ctrl !== 5'b01000) begin n_fail++; $display("FAIL rd0_regwrite: got ctrl=%b want 01000", exm_ctrl); end
        drive_id('0);
        @(negedge clk);
        n_checks++; if (exm_result !== 32'hF8000000) begin n_fail++; $display("FAIL sra: got %h want f8000000", exm_result); end
    endtask

    task automatic test_illegal_code();
        @(negedge clk); drive_id(mk(32'd3, 32'd5, 32'd0, 5'd1, 2'b01, 3'b000, 1'b0, 5'b00010));
        @(negedge clk); drive_id('0); ovr_en = 1'b1; ovr_code = 4'b1010;
        @(negedge clk); ovr_en = 1'b0;
        n_checks++; if (exm_result !== 32'd0 || exm_branch_taken !== 1'b1) begin n_fail++; $display("FAIL illegal_code: got %h bt=%b want 0 bt=1", exm_result, exm_branch_taken); end
    endtask

    task automatic test_async_reset();
        @(negedge clk); drive_id(mk(32'd5, 32'd7, 32'd0, 5'd3, 2'b10, 3'b001, 1'b0, 5'b10011));
        @(negedge clk); drive_id(mk(32'd6, 32'd6, 32'd0, 5'd4, 2'b01, 3'b000, 1'b0, 5'b00010));
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_checks++; if ({exm_result, exm_store_data} !== 64'd0) begin n_fail++; $display("FAIL async_rst_data: got %h %h want 0", exm_result, exm_store_data); end
        n_checks++; if ({exm_rd, exm_ctrl, exm_branch_taken, alu_op, ex_rs} !== 23'd0) begin n_fail++; $display("FAIL async_rst_ctl: got rd=%0d ctrl=%b bt=%b aop=%b rs=%h want 0", exm_rd, exm_ctrl, exm_branch_taken, alu_op, ex_rs); end
        @(negedge clk); rst = 1'b0; drive_id('0);
    endtask

    task automatic test_random();
        instr_t inflight, nxt;
        logic [31:0] e_res, e_store, a, fb, b;
        logic [4:0]  e_rd, e_ctrl;
        logic        e_bt;
        logic [3:0]  fs;
        logic [31:0] mv, wv;
        // Start from a known state.
        @(negedge clk); rst = 1'b1; stall = 0; flush = 0; drive_id('0);
        @(negedge clk); rst = 1'b0;
        inflight = '0; e_res = 0; e_store = 0; e_rd = 0; e_ctrl = 0; e_bt = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            n_checks++; if (exm_result !== e_res) begin n_fail++; $display("FAIL rnd_result[%0d]: got %h want %h", i, exm_result, e_res); end
            n_checks++; if (exm_store_data !== e_store) begin n_fail++; $display("FAIL rnd_store[%0d]: got %h want %h", i, exm_store_data, e_store); end
            n_checks++; if (exm_rd !== e_rd || exm_ctrl !== e_ctrl) begin n_fail++; $display("FAIL rnd_rd_ctrl[%0d]: got %0d %b want %0d %b", i, exm_rd, exm_ctrl, e_rd, e_ctrl); end
            n_checks++; if (exm_branch_taken !== e_bt) begin n_fail++; $display("FAIL rnd_bt[%0d]: got %b want %b", i, exm_branch_taken, e_bt); end
            n_checks++; if (alu_op !== inflight.aop || funct3 !== inflight.f3 || funct7_bit !== inflight.f7 || ex_rs !== inflight.rs) begin n_fail++; $display("FAIL rnd_idex[%0d]: got %b %b %b %h want %b %b %b %h", i, alu_op, funct3, funct7_bit, ex_rs, inflight.aop, inflight.f3, inflight.f7, inflight.rs); end

            stall = ($urandom_range(0, 7) == 0);
            flush = ($urandom_range(0, 9) == 0);
            fs = 4'($urandom);
            mv = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            wv = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            fwd_sel = fs; mem_fwd_data = mv; wb_fwd_data = wv;
            nxt.r1   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            nxt.r2   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            nxt.imm  = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            nxt.rs   = 10'($urandom);
            nxt.rd   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            nxt.aop  = 2'($urandom);
            nxt.f3   = 3'($urandom);
            nxt.f7   = 1'($urandom);
            nxt.ctrl = 5'($urandom);
            drive_id(nxt);

            // Effect of the coming rising edge.
            if (!stall) begin
                a  = pick(fs[1:0], inflight.r1, mv, wv);
                fb = pick(fs[3:2], inflight.r2, mv, wv);
                b  = inflight.ctrl[0] ? inflight.imm : fb;
                e_res   = ref_result(inflight.aop, inflight.f3, inflight.f7, a, b);
                e_store = fb;
                e_rd    = inflight.rd;
                e_ctrl  = inflight.ctrl;
                if (inflight.rd == 5'd0) e_ctrl[4] = 1'b0;
                e_bt    = inflight.ctrl[1] && (e_res == 32'd0);
            end
            if (flush) inflight = '0;
            else if (!stall) inflight = nxt;
        end
        stall = 0; flush = 0; fwd_sel = 0;
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_beq();
        test_forward();
        test_stall_flush();
        test_rd_zero_sra();
        test_illegal_code();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
